// File: rtl/dig_scan_driver_pkg.sv
// rtl/dig_scan_driver_pkg.sv - shared constants and helpers for the 8-digit scan driver
// Purpose: digit register offset, digit count, blank pattern, active-low
//          segment constants {DP,G,F,E,D,C,B,A} and a leading-digit helper.
package dig_scan_driver_pkg;

  localparam logic [11:0] DIG_OFFSET = 12'h000;
  localparam int          NUM_DIGITS = 8;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  // Index of the highest nonzero nibble; 0 when the whole word is zero so
  // digit 0 always remains visible.
  function automatic logic [2:0] lead_digit(input logic [31:0] value);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (value[4*i +: 4] != 4'h0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dig_scan_driver_if.sv
// rtl/dig_scan_driver_if.sv - bridge-side write bus for the digit register
// Purpose: groups the bridge write signals.
// Signals: addr  - 12-bit peripheral offset
//          wen   - write strobe, qualified by the bridge
//          wdata - 32-bit write data, nibble i drives digit i
// Modports: master (bridge drives), slave (display consumes).
interface dig_scan_driver_if;
  logic [11:0] addr;
  logic        wen;
  logic [31:0] wdata;

  modport master (output addr, output wen, output wdata);
  modport slave  (input addr, input wen, input wdata);
endinterface

// File: rtl/dig_scan_driver_seg7_hex_decode.sv
// rtl/dig_scan_driver_seg7_hex_decode.sv - combinational hex to 7-segment decoder
// Purpose: maps a nibble to an active-low {DP,G,F,E,D,C,B,A} pattern, DP off.
// Ports: i_nibble - 4-bit hex value
//        o_seg    - 8-bit active-low segment pattern
module seg7_hex_decode
  import dig_scan_driver_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dig_scan_driver.sv
// rtl/dig_scan_driver.sv - eight-digit multiplexed 7-segment display driver
// Purpose: latches a 32-bit value from the bridge and scans its 8 hex nibbles
//          onto shared active-low segment lines, one digit per SCAN_DIV cycles.
// Optional: DIG_LEAD_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
// Ports: clk    - system clock
//        rst    - asynchronous active-low reset
//        bus    - bridge write bus (slave modport: addr, wen, wdata)
//        dig_en - active-low digit enables, one-hot-low while scanning
//        seg    - active-low segments {DP,G,F,E,D,C,B,A}
module dig_scan_driver
  import dig_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dig_scan_driver_if.slave      bus,
  output logic [7:0]            dig_en,
  output logic [7:0]            seg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      r_data;
  logic [CNT_W-1:0] r_scan_cnt;
  logic [2:0]       r_dig_idx;
  logic [3:0]       w_nibble;
  logic [7:0]       w_seg;
  logic             w_blank;

  assign w_nibble = r_data[{r_dig_idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

`ifdef DIG_LEAD_ZERO_BLANK_EN
  assign w_blank = (r_dig_idx > lead_digit(r_data));
`else
  assign w_blank = 1'b0;
`endif

  // Outputs are computed from the pre-edge data/index, so a write or a digit
  // step at edge k becomes visible at edge k+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data     <= 32'h0;
      r_scan_cnt <= '0;
      r_dig_idx  <= 3'd0;
      dig_en     <= 8'hFF;
      seg        <= SEG_BLANK;
    end else begin
      if (bus.wen && (bus.addr == DIG_OFFSET)) r_data <= bus.wdata;

      if (r_scan_cnt == CNT_LAST) begin
        r_scan_cnt <= '0;
        r_dig_idx  <= r_dig_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end

      if (w_blank) begin
        dig_en <= 8'hFF;
        seg    <= SEG_BLANK;
      end else begin
        dig_en <= ~(8'b1 << r_dig_idx);
        seg    <= w_seg;
      end
    end
  end

endmodule

// File: tb/tb_dig_scan_driver.sv
// tb/tb_dig_scan_driver.sv - self-checking bench for dig_scan_driver
module tb_dig_scan_driver;

  localparam int SD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] dig_en;
  logic [7:0] seg;

  dig_scan_driver_if bus ();

  dig_scan_driver #(.SCAN_DIV(SD), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .dig_en (dig_en),
    .seg    (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: displayed value and edges since reset release.
  logic [31:0] m_data;
  int          n_edges;
  logic [7:0]  seg_tab [16];

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h at n=%0d", tag, obs, exp, n_edges);
    end
  endtask

  // One clock: present inputs, take the edge, advance the model, compare.
  task automatic cycle(input logic w, input logic [11:0] a, input logic [31:0] d);
    logic [31:0] prev;
    int          idx;
    int          hi;
    logic [7:0]  exp_en;
    logic [7:0]  exp_seg;
    bus.wen   = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    prev = m_data;
    if (w && a == 12'h000) m_data = d;
    n_edges++;
    idx     = ((n_edges - 1) / SD) % 8;
    exp_en  = ~(8'(1) << idx);
    exp_seg = seg_tab[(prev >> (4 * idx)) & 32'hF];
`ifdef DIG_LEAD_ZERO_BLANK_EN
    hi = 0;
    for (int i = 0; i < 8; i++) if (((prev >> (4 * i)) & 32'hF) != 0) hi = i;
    if (idx > hi) begin
      exp_en  = 8'hFF;
      exp_seg = 8'hFF;
    end
`else
    hi = 7;
`endif
    #1;
    check8("dig_en", dig_en, exp_en);
    check8("seg", seg, exp_seg);
  endtask

  task automatic idle(input int count);
    for (int i = 0; i < count; i++) cycle(1'b0, 12'h000, 32'h0);
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check8("async_rst_en", dig_en, 8'hFF);
    check8("async_rst_seg", seg, 8'hFF);
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    check8("rst_hold_en", dig_en, 8'hFF);
    check8("rst_hold_seg", seg, 8'hFF);
    rst     = 1'b1;
    m_data  = 32'h0;
    n_edges = 0;
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    m_data    = 32'h0;
    n_edges   = 0;
    bus.wen   = 1'b0;
    bus.addr  = 12'h000;
    bus.wdata = 32'h0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Plain scan through all eight digits and the wrap back to digit 0.
    idle(8 * SD + SD);

    // Nibble-per-digit write.
    cycle(1'b1, 12'h000, 32'h8765_4321);
    idle(8 * SD + 2);

    // Write at a foreign offset is ignored.
    cycle(1'b1, 12'h004, 32'hFFFF_FFFF);
    idle(8 * SD);

    // Back-to-back writes, the second landing on a scan wrap edge.
    while ((n_edges % SD) != SD - 2) idle(1);
    cycle(1'b1, 12'h000, 32'h0000_000F);
    cycle(1'b1, 12'h000, 32'h0000_00A0);
    idle(8 * SD);

    // Leading-zero patterns.
    cycle(1'b1, 12'h000, 32'h0000_0305);
    idle(8 * SD);
    cycle(1'b1, 12'h000, 32'h0000_0000);
    idle(8 * SD);

    // Randomized writes at mixed offsets with variable leading zeros.
    for (int i = 0; i < 300; i++) begin
      logic        w;
      logic [11:0] a;
      logic [31:0] d;
      w = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 2) != 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      d = $urandom >> (4 * $urandom_range(0, 8));
      cycle(w, a, d);
    end

    // Reset mid-scan with nonzero data, then confirm clean restart.
    cycle(1'b1, 12'h000, 32'hDEAD_BEEF);
    idle(SD + 1);
    hold_reset();
    idle(8 * SD + SD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dig_scan_driver.md
Name: dig_scan_driver

Overview:
- Eight-digit multiplexed 7-segment display peripheral, directly downstream of the CPU/peripheral bridge.
- Consumes the bridge's digit-port write strobe, 12-bit offset and 32-bit write data, and latches a 32-bit value shown as 8 hex nibbles.
- Time-multiplexes the nibbles onto shared segment lines with a free-running scan counter and a digit-select ring.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit; legal range ≥2.
- CNT_W, 16, scan counter width; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
- clk  input  1  system clock, shared with CPU and bridge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- addr  input  12  peripheral offset from the bridge.
- wen  input  1  write strobe, already qualified by the bridge for the digit address.
- wdata  input  32  write data; nibble i goes to digit i (digit 0 = rightmost).
- dig_en  output  8  digit anode enables, active-low, one-hot-low while scanning.
- seg  output  8  segments {DP,G,F,E,D,C,B,A}, active-low.

Behaviour:
- Reset (rst=0, async): data_reg=0, scan_cnt=0, dig_idx=0, dig_en=8'hFF, seg=8'hFF. All outputs are registered, so nothing glitches during reset.
- Write: at a clk edge with wen=1 and addr==DIG_OFFSET (12'h000), data_reg<=wdata. Writes at any other offset are ignored.
- Scan counter: scan_cnt increments every cycle.
  - When scan_cnt==SCAN_DIV-1 it wraps to 0 and dig_idx<=(dig_idx+1) mod 8; 7 wraps to 0.
- Output register, updated every cycle outside reset:
  - dig_en<=~(8'b1<<dig_idx).
  - seg<=hex_decode(data_reg[4*dig_idx+:4]), DP bit always 1 (off).
- Latency:
  - A write at edge k updates data_reg at k; seg reflects it at edge k+1 if that digit is selected, otherwise on its next scan slot.
  - A dig_idx change at edge k appears on dig_en/seg at edge k+1. dig_en and seg always switch on the same edge.
- First cycle after reset release: dig_en=8'hFE, showing digit 0 of data 0 (seg=8'hC0).
- Write coinciding with a scan wrap: both take effect; the next output update uses the new data_reg and the new dig_idx.
- Back-to-back writes: the last one wins; no buffering.
- Reset mid-scan: returns immediately to digit 0 and clears data_reg.
- Hex decode (active-low, {G..A}):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - The values include DP=1.

Optional Feature:
- Macro DIG_LEAD_ZERO_BLANK_EN.
- Defined: leading-zero blanking. Every digit above the highest nonzero nibble of data_reg has its dig_en bit forced to 1 in its slot (dig_en=8'hFF), and seg=8'hFF. Digit 0 is always shown, so data 0 shows a single "0". Scan timing is unchanged.
- Undefined: all 8 digits are always driven.

Decomposition:
- Shared package/header defines:
  - DIG_OFFSET=12'h000.
  - NUM_DIGITS=8.
  - SEG_BLANK=8'hFF.
  - The 16-entry segment constants SEG_0..SEG_F.
- One sub-module: seg7_hex_decode. It is purely combinational, takes a 4-bit nibble and returns an 8-bit active-low pattern.
- Counter, digit ring and registers stay in dig_scan_driver.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-scan -> dig_en=8'hFF and seg=8'hFF asynchronously; first edge after release gives dig_en=8'hFE, seg=8'hC0.
- Scan with SCAN_DIV=4, no writes -> dig_en steps FE,FD,FB,F7,EF,DF,BF,7F, 4 cycles each, then wraps to FE.
- Write wdata=32'h8765_4321 at addr 0 -> over one full scan, seg per digit 0..7 = F9,A4,B0,99,92,82,F8,80.
- Write at addr=12'h004 with wen=1 -> data_reg unchanged; display pattern identical to before.
- Write coinciding with a scan wrap, 0x0000_000F then 0x0000_00A0 on consecutive cycles -> digit 1 shows 88 and digit 0 shows C0 in their next slots; no intermediate 8E visible after the second write's update edge.
- With DIG_LEAD_ZERO_BLANK_EN and data 32'h0000_0305:
  - slots 3..7 give dig_en=FF, seg=FF;
  - digits 0..2 show 92, C0, B0.
  - With data 0: only digit 0 is lit, showing C0.
